// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU result checker: opcodes, checker states
// and the default ALU data width.
package alu_chk_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } chk_state_e;

endpackage

// File: rtl/alu_result_checker_golden.sv
// Combinational golden model of the 4-bit ALU (alu_golden_model); results are
// taken modulo 2^DATA_W, so carries and borrows fall off the top.
module alu_golden_model
  import alu_chk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] expected
);

  // Reference result for every opcode
  always_comb begin
    expected = '0;
    case (op)
      OP_ADD:  expected = in1 + in2;
      OP_SUB:  expected = in1 - in2;
      OP_AND:  expected = in1 & in2;
      OP_OR:   expected = in1 | in2;
      OP_XOR:  expected = in1 ^ in2;
      OP_NOT:  expected = ~in1;
      OP_SHL:  expected = {in1[DATA_W-2:0], 1'b0};
      OP_SHR:  expected = {1'b0, in1[DATA_W-1:1]};
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Self-checking ALU output monitor: two-stage compare pipeline, saturating
// pass/fail counters and session FSM. Optional ALU_CHK_FIRST_FAIL_CAPTURE_EN.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              smp_valid,
  output logic              smp_ready,
  input  logic [2:0]        smp_op,
  input  logic [DATA_W-1:0] smp_in1,
  input  logic [DATA_W-1:0] smp_in2,
  input  logic [DATA_W-1:0] smp_out,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              mismatch,
  output logic              busy,
  output logic              result_valid,
  output logic              result_pass
`ifdef ALU_CHK_FIRST_FAIL_CAPTURE_EN
  ,
  output logic              fail_seen,
  output logic [2:0]        fail_op,
  output logic [DATA_W-1:0] fail_in1,
  output logic [DATA_W-1:0] fail_in2,
  output logic [DATA_W-1:0] fail_got,
  output logic [DATA_W-1:0] fail_exp
`endif
);

  chk_state_e        state_r;
  logic [DATA_W-1:0] exp_s;
  logic              accept_s;
  logic              restart_s;
  logic              count_en_s;
  logic              match_s;
  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_exp_r;
  logic [DATA_W-1:0] s1_out_r;
  logic [CNT_W-1:0]  pass_nxt_s;
  logic [CNT_W-1:0]  fail_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  alu_golden_model #(.DATA_W(DATA_W)) u_golden (
    .op       (smp_op),
    .in1      (smp_in1),
    .in2      (smp_in2),
    .expected (exp_s)
  );

  assign smp_ready  = (state_r == RUN);
  assign accept_s   = smp_valid && (state_r == RUN);
  // A restart discards whatever is in flight, including this cycle's sample.
  assign restart_s  = start && (state_r == RUN);
  assign count_en_s = s1_valid_r && !restart_s;
  assign match_s    = (s1_exp_r == s1_out_r);

  // Saturating next values of the pass/fail counters
  always_comb begin
    pass_nxt_s = pass_cnt;
    fail_nxt_s = fail_cnt;
    if (count_en_s && match_s) begin
      pass_nxt_s = sat_inc(pass_cnt);
    end else if (count_en_s) begin
      fail_nxt_s = sat_inc(fail_cnt);
    end else begin
      pass_nxt_s = pass_cnt;
      fail_nxt_s = fail_cnt;
    end
  end

  // Stage 1: register expected value and observed result of accepted samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_exp_r   <= '0;
      s1_out_r   <= '0;
    end else if (restart_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_exp_r <= exp_s;
        s1_out_r <= smp_out;
      end
    end
  end

  // Session FSM with counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      mismatch     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
    end else begin
      mismatch <= count_en_s && !match_s;
      pass_cnt <= pass_nxt_s;
      fail_cnt <= fail_nxt_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= RUN;
            busy     <= 1'b1;
            pass_cnt <= '0;
            fail_cnt <= '0;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            state_r  <= RUN;
            pass_cnt <= '0;
            fail_cnt <= '0;
          end else if (finish) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          // Verdict uses the counts including the last in-flight sample
          state_r      <= REPORT;
          busy         <= 1'b0;
          result_valid <= 1'b1;
          result_pass  <= (fail_nxt_s == '0) && (pass_nxt_s != '0);
        end
        REPORT: begin
          if (start) begin
            state_r      <= RUN;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            result_pass  <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
          end else begin
            state_r <= REPORT;
          end
        end
        default: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
          result_pass  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_CHK_FIRST_FAIL_CAPTURE_EN
  logic              session_clr_s;
  logic [2:0]        s1_op_r;
  logic [DATA_W-1:0] s1_in1_r;
  logic [DATA_W-1:0] s1_in2_r;

  assign session_clr_s = start && (state_r != DRAIN);

  // Stage 1 copy of opcode and operands, needed only for failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_op_r  <= 3'b000;
      s1_in1_r <= '0;
      s1_in2_r <= '0;
    end else if (accept_s) begin
      s1_op_r  <= smp_op;
      s1_in1_r <= smp_in1;
      s1_in2_r <= smp_in2;
    end else begin
      s1_op_r  <= s1_op_r;
      s1_in1_r <= s1_in1_r;
      s1_in2_r <= s1_in2_r;
    end
  end

  // Latch the first failing sample of the session
  always_ff @(posedge clk) begin
    if (rst || session_clr_s) begin
      fail_seen <= 1'b0;
      fail_op   <= 3'b000;
      fail_in1  <= '0;
      fail_in2  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else if (count_en_s && !match_s && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_op   <= s1_op_r;
      fail_in1  <= s1_in1_r;
      fail_in2  <= s1_in2_r;
      fail_got  <= s1_out_r;
      fail_exp  <= s1_exp_r;
    end else begin
      fail_seen <= fail_seen;
    end
  end
`endif

endmodule
